// File: rtl/mmio_ctrl.sv
// Memory-mapped IO block for the MEM stage.
// It holds debounced switch/button inputs, the LED and seven-segment registers,
// a scanned eight-digit display, and a button-wait handshake that stalls the pipeline.

// Per-signal-group input conditioner: 2-flop synchronizer followed by a debouncer.
// The output changes only after the synchronized value has differed from it for
// DEB_CYCLES consecutive cycles with no intermediate change.
module mmio_debounce #(
    parameter int W          = 1,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [W-1:0]  s1, s2, last;
    logic [CW-1:0] cnt;

    // Synchronize, then count consecutive stable cycles of a value that differs from dout
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1   <= '0;
            s2   <= '0;
            last <= '0;
            cnt  <= '0;
            dout <= '0;
        end else begin
            s1   <= din;
            s2   <= s1;
            last <= s2;
            if (s2 == dout) begin
                cnt <= '0;
            end else if (s2 != last) begin
                // first cycle of a new candidate value
                cnt <= CW'(1);
            end else if (cnt >= CW'(DEB_CYCLES - 1)) begin
                dout <= s2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

module mmio_ctrl #(
    parameter int DEB_CYCLES  = 1000000,
    parameter int SCAN_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic        io_sel,
    output logic [31:0] rdata,
    output logic        io_stall,
    input  logic [15:0] sw,
    input  logic        btn,
    output logic [15:0] led,
    output logic [7:0]  seg_an,
    output logic [7:0]  seg_out
);
    localparam int SC = $clog2(SCAN_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, WAIT_REL, WAIT_PRESS, DONE} btn_state_t;

    btn_state_t    state, state_nx;
    logic [15:0]   sw_deb;
    logic          btn_deb;
    logic [31:0]   seg_reg;
    logic [SC-1:0] scan_cnt;
    logic [2:0]    idx;
    logic [3:0]    nib;
    logic          btn_rd, wr_led, wr_seg, done;
    logic          unused_addr;

    // Byte offset bits carry no meaning in a word-mapped window
    assign unused_addr = &{1'b0, addr[1:0]};

    assign io_sel = &addr[31:10];
    assign btn_rd = mem_read  && io_sel && (addr[9:2] == 8'h01);
    assign wr_led = mem_write && io_sel && (addr[9:2] == 8'h04);
    assign wr_seg = mem_write && io_sel && (addr[9:2] == 8'h08);

    mmio_debounce #(.W(16), .DEB_CYCLES(DEB_CYCLES)) u_sw_deb (
        .clk(clk), .rst(rst), .din(sw), .dout(sw_deb)
    );
    mmio_debounce #(.W(1), .DEB_CYCLES(DEB_CYCLES)) u_btn_deb (
        .clk(clk), .rst(rst), .din(btn), .dout(btn_deb)
    );

    // LED and SEG registers load on a store to their address
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led     <= '0;
            seg_reg <= '0;
        end else begin
            if (wr_led) led     <= wdata[15:0];
            if (wr_seg) seg_reg <= wdata;
        end
    end

    // Button-wait state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Button-wait transitions; losing the read (flush) abandons the wait.
    // WAIT_PRESS is only ever entered with btn_deb low, so btn_deb high there is a 0->1 edge.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:       if (btn_rd) state_nx = btn_deb ? WAIT_REL : WAIT_PRESS;
            WAIT_REL:   if (!btn_rd) state_nx = IDLE;
                        else if (!btn_deb) state_nx = WAIT_PRESS;
            WAIT_PRESS: if (!btn_rd) state_nx = IDLE;
                        else if (btn_deb) state_nx = DONE;
            DONE:       state_nx = IDLE;
            default:    state_nx = IDLE;
        endcase
    end

    // Stall while a button-wait read is outstanding; release in DONE so the load retires
    always_comb begin
        io_stall = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE, WAIT_REL, WAIT_PRESS: io_stall = btn_rd;
            DONE:                       done     = 1'b1;
            default:                    io_stall = 1'b0;
        endcase
    end

    // IO read mux; unmapped and out-of-window reads return zero
    always_comb begin
        rdata = '0;
        if (io_sel) begin
            case (addr[9:2])
                8'h00:   rdata = {16'b0, sw_deb};
                8'h01:   rdata = {31'b0, done};
                default: rdata = '0;
            endcase
        end
    end

    // Digit scan: slot timer and digit index, free-running across SEG updates
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt >= SC'(SCAN_CYCLES - 1)) begin
            scan_cnt <= '0;
            idx      <= idx + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + SC'(1);
        end
    end

    assign seg_an = ~(8'b1 << idx);
    assign nib    = seg_reg[{idx, 2'b00} +: 4];

    // Active-low hex decode, {dp,g..a}, dp held off
    always_comb begin
        seg_out = 8'hFF;
        case (nib)
            4'h0: seg_out = 8'hC0;
            4'h1: seg_out = 8'hF9;
            4'h2: seg_out = 8'hA4;
            4'h3: seg_out = 8'hB0;
            4'h4: seg_out = 8'h99;
            4'h5: seg_out = 8'h92;
            4'h6: seg_out = 8'h82;
            4'h7: seg_out = 8'hF8;
            4'h8: seg_out = 8'h80;
            4'h9: seg_out = 8'h90;
            4'hA: seg_out = 8'h88;
            4'hB: seg_out = 8'h83;
            4'hC: seg_out = 8'hC6;
            4'hD: seg_out = 8'hA1;
            4'hE: seg_out = 8'h86;
            4'hF: seg_out = 8'h8E;
            default: seg_out = 8'hFF;
        endcase
    end
endmodule

// File: tb/tb_mmio_ctrl.sv
// Directed bench for mmio_ctrl with DEB_CYCLES=4, SCAN_CYCLES=2.
module tb_mmio_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic        io_sel, io_stall, btn = 1'b0;
    logic [31:0] rdata;
    logic [15:0] sw = '0, led;
    logic [7:0]  seg_an, seg_out, prev_an;
    logic [7:0]  dec_tab [8];
    int          checks = 0, failures = 0;
    bit          found;

    localparam logic [31:0] A_SW  = 32'hFFFF_FC00;
    localparam logic [31:0] A_BTN = 32'hFFFF_FC04;
    localparam logic [31:0] A_LED = 32'hFFFF_FC10;
    localparam logic [31:0] A_SEG = 32'hFFFF_FC20;

    mmio_ctrl #(.DEB_CYCLES(4), .SCAN_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata),
        .mem_read(mem_read), .mem_write(mem_write), .io_sel(io_sel),
        .rdata(rdata), .io_stall(io_stall), .sw(sw), .btn(btn),
        .led(led), .seg_an(seg_an), .seg_out(seg_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // advance n rising edges, landing 1 time unit after the last one
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        dec_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};

        // reset state
        #3;
        chk("rst_led", {16'b0, led}, 32'h0);
        chk("rst_an", {24'b0, seg_an}, 32'hFE);
        chk("rst_seg", {24'b0, seg_out}, 32'hC0);
        chk("rst_stall", {31'b0, io_stall}, 32'h0);
        step(2);
        rst = 1'b1;
        step(1);

        // LED store, store to read-only SW ignored
        addr = A_LED; wdata = 32'h0000_A5A5; mem_write = 1'b1;
        #1 chk("io_sel_hit", {31'b0, io_sel}, 32'h1);
        step(1);
        mem_write = 1'b0;
        chk("led_write", {16'b0, led}, 32'h0000_A5A5);
        addr = A_SW; wdata = 32'h0000_FFFF; mem_write = 1'b1;
        step(1);
        mem_write = 1'b0;
        chk("led_keep", {16'b0, led}, 32'h0000_A5A5);

        // out-of-window and unmapped reads
        addr = 32'h0000_1000; mem_read = 1'b1;
        #1 chk("io_sel_miss", {31'b0, io_sel}, 32'h0);
        chk("rd_outside", rdata, 32'h0);
        addr = 32'hFFFF_FC08;
        #1 chk("rd_unmapped", rdata, 32'h0);
        mem_read = 1'b0;

        // switch debounce: sync 2 + stability 4 -> visible after 6 edges
        sw = 16'h1234;
        step(8);
        addr = A_SW; mem_read = 1'b1;
        #1 chk("sw_read", rdata, 32'h0000_1234);
        sw = 16'hFFFF;
        step(2);
        sw = 16'h1234;
        step(8);
        chk("sw_glitch", rdata, 32'h0000_1234);
        sw = 16'h00FF;
        step(5);
        chk("sw_deb_early", rdata, 32'h0000_1234);
        step(1);
        chk("sw_deb_edge", rdata, 32'h0000_00FF);
        mem_read = 1'b0;

        // button wait, button initially released
        addr = A_BTN; mem_read = 1'b1;
        #1 chk("bw_idle_stall", {31'b0, io_stall}, 32'h1);
        chk("bw_idle_rdata", rdata, 32'h0);
        step(1);
        btn = 1'b1;
        step(6);
        chk("bw_press_stall", {31'b0, io_stall}, 32'h1);
        step(1);
        chk("bw_done_stall", {31'b0, io_stall}, 32'h0);
        chk("bw_done_rdata", rdata, 32'h1);
        mem_read = 1'b0;
        step(1);
        chk("bw_after_stall", {31'b0, io_stall}, 32'h0);
        chk("bw_after_rdata", rdata, 32'h0);

        // button wait with button already held: release, then press again
        mem_read = 1'b1;
        step(1);
        btn = 1'b0;
        step(7);
        chk("bw_rel_stall", {31'b0, io_stall}, 32'h1);
        step(5);
        chk("bw_wp_stall", {31'b0, io_stall}, 32'h1);
        btn = 1'b1;
        step(6);
        chk("bw_wp2_stall", {31'b0, io_stall}, 32'h1);
        step(1);
        chk("bw2_done_stall", {31'b0, io_stall}, 32'h0);
        chk("bw2_done_rdata", rdata, 32'h1);
        mem_read = 1'b0;
        btn = 1'b0;
        step(8);

        // abort during WAIT_PRESS
        mem_read = 1'b1;
        step(1);
        chk("ab_wp_stall", {31'b0, io_stall}, 32'h1);
        mem_read = 1'b0;
        #1 chk("ab_drop_stall", {31'b0, io_stall}, 32'h0);
        // with the FSM back in IDLE, a fresh read against a held button must wait for release
        btn = 1'b1;
        step(8);
        mem_read = 1'b1;
        step(1);
        chk("ab_reread_stall", {31'b0, io_stall}, 32'h1);
        chk("ab_reread_rdata", rdata, 32'h0);

        // asynchronous reset mid-wait
        #2 rst = 1'b0;
        #1 chk("arst_led", {16'b0, led}, 32'h0);
        chk("arst_an", {24'b0, seg_an}, 32'hFE);
        // IDLE with the read still presented requests a stall; dropping it releases
        chk("arst_stall_rd", {31'b0, io_stall}, 32'h1);
        mem_read = 1'b0;
        #1 chk("arst_stall", {31'b0, io_stall}, 32'h0);
        btn = 1'b0;
        step(1);
        rst = 1'b1;
        step(1);
        chk("arst_rdata", rdata, 32'h0);

        // seven-segment scan
        addr = A_SEG; wdata = 32'h7654_3210; mem_write = 1'b1;
        step(1);
        mem_write = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            prev_an = seg_an;
            step(1);
            if (seg_an == 8'hFE && prev_an == 8'h7F) found = 1'b1;
        end
        chk("scan_sync", {31'b0, found}, 32'h1);
        if (found) begin
            for (int i = 0; i < 16; i++) begin
                chk($sformatf("scan_an_%0d", i), {24'b0, seg_an}, {24'b0, ~(8'b1 << (i / 2))});
                chk($sformatf("scan_seg_%0d", i), {24'b0, seg_out}, {24'b0, dec_tab[i / 2]});
                step(1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
